// File: rtl/pwm_gen_cfg_seq.sv
// pwm_gen_cfg_seq: programs the axi_pwm_gen register file from one configuration snapshot.
//
// A configuration offered on cfg_valid/cfg_ready is captured into shadow registers. The block
// then writes period, width and offset for each channel and finishes with a LOAD_CONFIG write
// to RSTN. Each write waits for up_wack. If no ack arrives within TIMEOUT cycles, the sequence
// aborts, sets the sticky error flag and skips every remaining write.
//
// Optional feature: define PWM_GEN_CFG_SEQ_READBACK_EN to read CORE_MAGIC before any write.
// The sequence aborts with no writes if the magic value does not match.
//
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   cfg_valid/cfg_ready               configuration handshake
//   cfg_period/width/offset           per-channel 32-bit fields, channel n at [32n+31:32n]
//   busy, done, error                 sequence status (done pulses once; error is sticky)
//   up_wreq/waddr/wdata/wack          word-addressed write channel
//   up_rreq/raddr/rdata/rack          word-addressed read channel (readback build only)
module pwm_gen_cfg_seq #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [32*NUM_CH-1:0]  cfg_period,
  input  logic [32*NUM_CH-1:0]  cfg_width,
  input  logic [32*NUM_CH-1:0]  cfg_offset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  up_wreq,
  output logic [13:0]           up_waddr,
  output logic [31:0]           up_wdata,
  input  logic                  up_wack,
  output logic                  up_rreq,
  output logic [13:0]           up_raddr,
  input  logic [31:0]           up_rdata,
  input  logic                  up_rack
);

  // One extra code point so ch_q == NUM_CH selects the final LOAD_CONFIG write.
  localparam int unsigned ChW = $clog2(NUM_CH + 1);

  typedef enum logic [2:0] {
    StIdle,
`ifdef PWM_GEN_CFG_SEQ_READBACK_EN
    StRdReq,
    StRdWait,
`endif
    StWrReq,
    StWrWait,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [ChW-1:0]       ch_q, ch_d;
  logic [1:0]           fld_q, fld_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 rdy_q, rdy_d;
  logic [32*NUM_CH-1:0] period_q, period_d;
  logic [32*NUM_CH-1:0] width_q, width_d;
  logic [32*NUM_CH-1:0] offset_q, offset_d;

  logic                 timeout_hit;
  logic [31:0]          sel_period, sel_width, sel_offset;

  assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    fld_d    = fld_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    period_d = period_q;
    width_d  = width_q;
    offset_d = offset_q;

    case (state_q)
      StIdle: begin
        if (cfg_valid && rdy_q) begin
          period_d = cfg_period;
          width_d  = cfg_width;
          offset_d = cfg_offset;
          err_d    = 1'b0;
          ch_d     = '0;
          fld_d    = '0;
          cnt_d    = '0;
`ifdef PWM_GEN_CFG_SEQ_READBACK_EN
          state_d  = StRdReq;
`else
          state_d  = StWrReq;
`endif
        end
      end
`ifdef PWM_GEN_CFG_SEQ_READBACK_EN
      StRdReq: begin
        cnt_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (up_rack) begin
          if (up_rdata == 32'h601A3471) begin
            state_d = StWrReq;
          end else begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      StWrReq: begin
        cnt_d   = '0;
        state_d = StWrWait;
      end
      StWrWait: begin
        if (up_wack) begin
          if (ch_q == ChW'(NUM_CH)) begin
            state_d = StDone;
          end else begin
            if (fld_q == 2'd2) begin
              fld_d = 2'd0;
              ch_d  = ch_q + ChW'(1);
            end else begin
              fld_d = fld_q + 2'd1;
            end
            state_d = StWrReq;
          end
        end else if (timeout_hit) begin
          // Abort skips every remaining write, LOAD_CONFIG included.
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // cfg_ready is registered so it rises one edge after reset release or after done.
    rdy_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      ch_q     <= '0;
      fld_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
      period_q <= '0;
      width_q  <= '0;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      fld_q    <= fld_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
      period_q <= period_d;
      width_q  <= width_d;
      offset_q <= offset_d;
    end
  end

  // Pick the current channel's shadow fields.
  always_comb begin
    sel_period = '0;
    sel_width  = '0;
    sel_offset = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == ChW'(i)) begin
        sel_period = period_q[32*i +: 32];
        sel_width  = width_q[32*i +: 32];
        sel_offset = offset_q[32*i +: 32];
      end
    end
  end

  // Address and data depend only on ch_q/fld_q, so they stay stable through WR_WAIT.
  always_comb begin
    up_waddr = '0;
    up_wdata = '0;
    if (state_q == StWrReq || state_q == StWrWait) begin
      if (ch_q == ChW'(NUM_CH)) begin
        up_waddr = 14'h004;
        up_wdata = 32'h0000_0002;
      end else begin
        unique case (fld_q)
          2'd0: begin
            up_waddr = 14'h010 + 14'(ch_q);
            up_wdata = sel_period;
          end
          2'd1: begin
            up_waddr = 14'h020 + 14'(ch_q);
            up_wdata = sel_width;
          end
          default: begin
            up_waddr = 14'h030 + 14'(ch_q);
            up_wdata = sel_offset;
          end
        endcase
      end
    end
  end

  assign cfg_ready = rdy_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign error     = err_q;
  assign up_wreq   = (state_q == StWrReq);

`ifdef PWM_GEN_CFG_SEQ_READBACK_EN
  assign up_rreq  = (state_q == StRdReq);
  assign up_raddr = (state_q == StRdReq || state_q == StRdWait) ? 14'h003 : 14'h000;
`else
  logic unused_rd;
  assign unused_rd = ^{up_rdata, up_rack};
  assign up_rreq   = 1'b0;
  assign up_raddr  = '0;
`endif

endmodule

// File: tb/tb_pwm_gen_cfg_seq.sv
// tb_pwm_gen_cfg_seq: directed bench for pwm_gen_cfg_seq (NUM_CH=2, TIMEOUT=8).
// Expected writes are queued when a configuration is offered and popped as up_wreq appears.
module tb_pwm_gen_cfg_seq;

  localparam int unsigned NCh = 2;
  localparam int unsigned To  = 8;

  logic              clk;
  logic              resetn;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [32*NCh-1:0] cfg_period, cfg_width, cfg_offset;
  logic              busy, done, error;
  logic              up_wreq;
  logic [13:0]       up_waddr;
  logic [31:0]       up_wdata;
  logic              up_wack;
  logic              up_rreq;
  logic [13:0]       up_raddr;
  logic [31:0]       up_rdata;
  logic              up_rack;

  pwm_gen_cfg_seq #(
    .NUM_CH  (NCh),
    .TIMEOUT (To)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_width  (cfg_width),
    .cfg_offset (cfg_offset),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .up_wreq    (up_wreq),
    .up_waddr   (up_waddr),
    .up_wdata   (up_wdata),
    .up_wack    (up_wack),
    .up_rreq    (up_rreq),
    .up_raddr   (up_raddr),
    .up_rdata   (up_rdata),
    .up_rack    (up_rack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int last_wreq_cyc = 0;
  int withhold = -1;
  logic wack_pend = 1'b0;
  logic rack_pend = 1'b0;
  logic stray_wack = 1'b0;
  logic [31:0] rd_val = 32'h601A3471;
  logic [13:0] exp_a[$];
  logic [31:0] exp_d[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Write monitor plus ack/read responders; everything sampled on the falling edge.
  always @(negedge clk) begin
    up_wack   = wack_pend | stray_wack;
    wack_pend = 1'b0;
    up_rack   = rack_pend;
    up_rdata  = rd_val;
    rack_pend = 1'b0;
    if (!resetn) begin
      up_wack = 1'b0;
      up_rack = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (up_rreq) rack_pend = 1'b1;
      if (up_wreq) begin
        if (wr_cnt != withhold) wack_pend = 1'b1;
        wr_cnt++;
        last_wreq_cyc = cyc;
        if (exp_a.size() == 0) begin
          check("write_expected", 32'(exp_a.size()), 32'd1);
        end else begin
          check("waddr", 32'(up_waddr), 32'(exp_a.pop_front()));
          check("wdata", up_wdata, exp_d.pop_front());
        end
      end
    end
  end

  task automatic push_seq(input logic [32*NCh-1:0] p, input logic [32*NCh-1:0] w,
                          input logic [32*NCh-1:0] o);
    for (int ch = 0; ch < NCh; ch++) begin
      exp_a.push_back(14'h010 + 14'(ch)); exp_d.push_back(p[32*ch +: 32]);
      exp_a.push_back(14'h020 + 14'(ch)); exp_d.push_back(w[32*ch +: 32]);
      exp_a.push_back(14'h030 + 14'(ch)); exp_d.push_back(o[32*ch +: 32]);
    end
    exp_a.push_back(14'h004); exp_d.push_back(32'h2);
  endtask

  // Offer a configuration at a cycle where cfg_ready is high; leave valid asserted if hold.
  task automatic offer(input logic [32*NCh-1:0] p, input logic [32*NCh-1:0] w,
                       input logic [32*NCh-1:0] o, input bit push, input bit hold);
    bit seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cfg_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("ready_before_offer", 32'(seen), 32'd1);
    cfg_period = p;
    cfg_width  = w;
    cfg_offset = o;
    cfg_valid  = 1'b1;
    if (push) push_seq(p, w, o);
    @(negedge clk);
    check("ready_drops_after_accept", 32'(cfg_ready), 32'd0);
    if (!hold) cfg_valid = 1'b0;
  endtask

  task automatic wait_done(output int done_cyc);
    bit seen = 1'b0;
    done_cyc = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic after_done();
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("ready_after_done", 32'(cfg_ready), 32'd1);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, dn0, dcyc;
    resetn     = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_width  = '0;
    cfg_offset = '0;
    up_wack    = 1'b0;
    up_rack    = 1'b0;
    up_rdata   = '0;

    // Reset values.
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_wreq", 32'(up_wreq), 32'd0);
    check("rst_waddr", 32'(up_waddr), 32'd0);
    check("rst_wdata", up_wdata, 32'd0);
    check("rst_rreq", 32'(up_rreq), 32'd0);
    check("rst_raddr", 32'(up_raddr), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("ready_first_edge", 32'(cfg_ready), 32'd1);

    // Two channels, immediate acks, full seven-write sequence.
    wr0 = wr_cnt; dn0 = done_cnt;
    offer({32'd200, 32'd100}, {32'd50, 32'd25}, {32'd10, 32'd0}, 1'b1, 1'b0);
    check("busy_running", 32'(busy), 32'd1);
    wait_done(dcyc);
    check("seq_error", 32'(error), 32'd0);
    after_done();
    check("seq_writes", 32'(wr_cnt - wr0), 32'd7);
    check("seq_queue_empty", 32'(exp_a.size()), 32'd0);
    check("seq_done_pulses", 32'(done_cnt - dn0), 32'd1);

    // Third write never acked: abort after TIMEOUT wait cycles, no LOAD_CONFIG.
    wr0 = wr_cnt;
    withhold = wr_cnt + 2;
    offer({32'd9, 32'd8}, {32'd7, 32'd6}, {32'd5, 32'd4}, 1'b1, 1'b0);
    wait_done(dcyc);
    check("to_error", 32'(error), 32'd1);
    check("to_latency", 32'(dcyc - last_wreq_cyc), 32'(To + 1));
    after_done();
    check("to_writes", 32'(wr_cnt - wr0), 32'd3);
    check("to_skipped", 32'(exp_a.size()), 32'd4);
    exp_a.delete(); exp_d.delete();
    withhold = -1;
    repeat (3) @(negedge clk);
    check("to_error_sticky", 32'(error), 32'd1);

    // Idle reset clears the sticky error.
    #2 resetn = 1'b0;
    #1;
    check("rst_clears_error", 32'(error), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Reset during the second write wait, then restart from channel 0.
    wr0 = wr_cnt;
    offer({32'd300, 32'd301}, {32'd302, 32'd303}, {32'd304, 32'd305}, 1'b1, 1'b0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (wr_cnt >= wr0 + 2) break;
    end
    check("mid_two_writes", 32'(wr_cnt - wr0), 32'd2);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_wreq", 32'(up_wreq), 32'd0);
    check("mid_waddr", 32'(up_waddr), 32'd0);
    check("mid_wdata", up_wdata, 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_error", 32'(error), 32'd0);
    exp_a.delete(); exp_d.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("mid_ready_after_rst", 32'(cfg_ready), 32'd1);
    wr0 = wr_cnt;
    offer({32'h11, 32'h22}, {32'h33, 32'h44}, {32'h55, 32'h66}, 1'b1, 1'b0);
    wait_done(dcyc);
    check("restart_error", 32'(error), 32'd0);
    after_done();
    check("restart_writes", 32'(wr_cnt - wr0), 32'd7);

    // Stray ack in IDLE, then cfg_valid held with new data while busy.
    wr0 = wr_cnt;
    @(posedge clk);
    stray_wack = 1'b1;
    @(posedge clk);
    stray_wack = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_no_write", 32'(wr_cnt - wr0), 32'd0);
    check("stray_idle", 32'(busy), 32'd0);
    offer({32'hA1, 32'hA0}, {32'hB1, 32'hB0}, {32'hC1, 32'hC0}, 1'b1, 1'b1);
    cfg_period = {32'hDEAD, 32'hBEEF};
    cfg_width  = {32'hFACE, 32'hCAFE};
    cfg_offset = {32'h1234, 32'h5678};
    wait_done(dcyc);
    cfg_valid = 1'b0;
    after_done();
    repeat (5) @(negedge clk);
    check("hold_writes", 32'(wr_cnt - wr0), 32'd7);
    check("hold_queue_empty", 32'(exp_a.size()), 32'd0);
    check("hold_idle", 32'(busy), 32'd0);

`ifdef PWM_GEN_CFG_SEQ_READBACK_EN
    // Bad magic: abort with no writes; good magic: full sequence.
    wr0 = wr_cnt;
    rd_val = 32'h12345678;
    offer({32'd1, 32'd2}, {32'd3, 32'd4}, {32'd5, 32'd6}, 1'b0, 1'b0);
    wait_done(dcyc);
    check("rb_bad_error", 32'(error), 32'd1);
    after_done();
    check("rb_bad_writes", 32'(wr_cnt - wr0), 32'd0);
    wr0 = wr_cnt;
    rd_val = 32'h601A3471;
    offer({32'd1, 32'd2}, {32'd3, 32'd4}, {32'd5, 32'd6}, 1'b1, 1'b0);
    wait_done(dcyc);
    check("rb_good_error", 32'(error), 32'd0);
    after_done();
    check("rb_good_writes", 32'(wr_cnt - wr0), 32'd7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
